// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: control, instruction-memory and core-side handshake signals of the fetch stage
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
  logic run;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  logic halted;
  modport master (
    input run, redirect_valid, redirect_addr, imem_rdata, instr_ready,
    output imem_rd, imem_addr, instr, instr_pc, instr_valid, halted
  );
  modport slave (
    output run, redirect_valid, redirect_addr, imem_rdata, instr_ready,
    input imem_rd, imem_addr, instr, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven fetch from a 1-cycle-latency memory into a 2-entry prefetch buffer with redirect and halt
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [31:0] buf_word [2];
  logic [ADDR_W-1:0] buf_pc [2];
  logic [1:0] count;
  logic inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic head_halt, redir, halt_go, flush, pop, push, issue, tail;
  assign head_halt = count != 2'd0 && buf_word[0] == HALT_WORD;
  assign redir = bus.redirect_valid && state != IDLE;
  assign halt_go = state == RUN && head_halt && !redir;
  assign flush = redir || halt_go;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign push = inflight && !flush;
  // buffered + in-flight after this cycle's pop must leave room for one more response
  assign issue = state == RUN && bus.run && !redir && ({1'b0, count} + 3'(inflight) - 3'(pop)) < 3'd2;
  assign tail = 1'(count - 2'(pop));
  assign bus.instr_valid = count != 2'd0 && !head_halt;
  assign bus.instr = count != 2'd0 ? buf_word[0] : '0;
  assign bus.instr_pc = count != 2'd0 ? buf_pc[0] : '0;
  assign bus.imem_rd = issue;
  assign bus.imem_addr = pc;
  assign bus.halted = state == HALTED;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.run ? RUN : IDLE) : redir ? RUN : halt_go ? HALTED : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= BOOT_ADDR;
      count <= 2'd0;
      inflight <= 1'b0;
      inflight_pc <= '0;
      buf_word[0] <= '0;
      buf_word[1] <= '0;
      buf_pc[0] <= '0;
      buf_pc[1] <= '0;
    end else begin
      pc <= redir ? bus.redirect_addr : issue ? pc + 1'b1 : pc;
      inflight <= issue && !halt_go;
      if (issue) inflight_pc <= pc;
      count <= flush ? 2'd0 : count + 2'(push) - 2'(pop);
      if (!flush && pop) begin
        buf_word[0] <= buf_word[1];
        buf_pc[0] <= buf_pc[1];
      end
      if (push) begin
        buf_word[tail] <= bus.imem_rdata;
        buf_pc[tail] <= inflight_pc;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed timing checks plus randomized run against an in-order instruction-stream model
module tb_instr_fetch_unit;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] rdata;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  instr_fetch_unit_if #(.ADDR_W(8)) bus ();
  instr_fetch_unit #(.ADDR_W(8), .BOOT_ADDR(8'd0), .HALT_WORD(HALT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_rd) rdata <= mem[bus.imem_addr];
  assign bus.imem_rdata = rdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic redirect_to(input logic [7:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = a;
    mid();
    step();
    bus.redirect_valid = 1'b0;
  endtask
  task automatic wait_halt(output int n, output logic hit);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (!hit && bus.halted) hit = 1'b1;
      if (!hit && bus.instr_valid && bus.instr_ready) n++;
      step();
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, 32'(bus.imem_rd), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_pc"}, 32'(bus.instr_pc), 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask
  // Stream model: accepted words must follow the fetch address sequence set by each accepted redirect
  initial begin
    logic active, redir_q, prev_halted, pop;
    logic [7:0] exp_pc, rd_pc;
    int outst;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        active = 1'b0;
        redir_q = 1'b0;
        prev_halted = 1'b0;
        exp_pc = 8'd0;
        rd_pc = 8'd0;
        outst = 0;
      end else begin
        pop = bus.instr_valid && bus.instr_ready;
        if (redir_q) check("redir_unhalt", 32'(bus.halted), 32'd0);
        if (!active) begin
          check("idle_rd", 32'(bus.imem_rd), 32'd0);
          check("idle_valid", 32'(bus.instr_valid), 32'd0);
        end
        if (bus.halted) begin
          outst = 0;
          check("halt_rd", 32'(bus.imem_rd), 32'd0);
          check("halt_valid", 32'(bus.instr_valid), 32'd0);
          if (!prev_halted) check("halt_cause", mem[exp_pc], HALT);
        end
        if (bus.imem_rd) begin
          check("rd_addr", 32'(bus.imem_addr), 32'(rd_pc));
          check("rd_run", 32'(bus.run), 32'd1);
          check("rd_bound", 32'(outst + 1 - int'(pop) <= 2), 32'd1);
        end
        if (bus.instr_valid) check("valid_not_halt", 32'(bus.instr == HALT), 32'd0);
        if (pop) begin
          check("pop_pc", 32'(bus.instr_pc), 32'(exp_pc));
          check("pop_word", bus.instr, mem[exp_pc]);
          exp_pc++;
          pops++;
        end
        outst = outst + int'(bus.imem_rd) - int'(pop);
        redir_q = active && bus.redirect_valid;
        if (redir_q) begin
          exp_pc = bus.redirect_addr;
          rd_pc = bus.redirect_addr;
          outst = 0;
        end else if (bus.imem_rd) rd_pc++;
        if (bus.run) active = 1'b1;
        prev_halted = bus.halted;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] held;
    logic hit;
    int n;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 8'd0;
    for (int a = 0; a < 256; a++) mem[a] = 32'(a) + 32'h100;
    step();
    step();
    mid();
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();
    step();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      mid();
      if (c < 3) check("sl_wait", 32'(bus.instr_valid), 32'd0);
      else begin
        check("sl_valid", 32'(bus.instr_valid), 32'd1);
        check("sl_pc", 32'(bus.instr_pc), 32'(c - 3));
        check("sl_word", bus.instr, 32'h100 + 32'(c - 3));
      end
      step();
    end
    bus.instr_ready = 1'b0;
    mid();
    held = bus.instr;
    check("bp_valid", 32'(bus.instr_valid), 32'd1);
    step();
    for (int i = 1; i < 6; i++) begin
      mid();
      check("bp_hold", bus.instr, held);
      check("bp_rd", 32'(bus.imem_rd), 32'd0);
      step();
    end
    bus.instr_ready = 1'b1;
    mid();
    check("bp_resume", bus.instr, held);
    step();
    step();
    redirect_to(8'h40);
    mid();
    check("rx_rd", 32'(bus.imem_rd), 32'd1);
    check("rx_addr", 32'(bus.imem_addr), 32'h40);
    check("rx_flush", 32'(bus.instr_valid), 32'd0);
    step();
    mid();
    check("rx_wait", 32'(bus.instr_valid), 32'd0);
    step();
    mid();
    check("rx_valid", 32'(bus.instr_valid), 32'd1);
    check("rx_pc", 32'(bus.instr_pc), 32'h40);
    check("rx_word", bus.instr, 32'h140);
    step();
    mem[3] = HALT;
    redirect_to(8'h00);
    wait_halt(n, hit);
    check("halt_seen", 32'(hit), 32'd1);
    check("halt_delivered", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      mid();
      check("halt_flag", 32'(bus.halted), 32'd1);
      check("halt_quiet", 32'(bus.imem_rd), 32'd0);
      step();
    end
    redirect_to(8'h00);
    mid();
    check("restart_halted", 32'(bus.halted), 32'd0);
    check("restart_rd", 32'(bus.imem_rd), 32'd1);
    check("restart_addr", 32'(bus.imem_addr), 32'd0);
    step();
    step();
    mid();
    check("restart_valid", 32'(bus.instr_valid), 32'd1);
    check("restart_pc", 32'(bus.instr_pc), 32'd0);
    step();
    wait_halt(n, hit);
    check("halt2_seen", 32'(hit), 32'd1);
    redirect_to(8'hFE);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      mid();
      check("wrap_valid", 32'(bus.instr_valid), 32'd1);
      check("wrap_pc", 32'(bus.instr_pc), 32'(8'(8'hFE + k)));
      step();
    end
    #3;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("areset");
    mem[3] = 32'h103;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.redirect_valid = i == 1;
      bus.redirect_addr = 8'h80;
      mid();
      check("post_rst_valid", 32'(bus.instr_valid), 32'd0);
      check("post_rst_rd", 32'(bus.imem_rd), 32'd0);
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      if (c == 1) begin
        check("boot_rd", 32'(bus.imem_rd), 32'd1);
        check("boot_addr", 32'(bus.imem_addr), 32'd0);
      end
      if (c == 3) begin
        check("boot_pc", 32'(bus.instr_pc), 32'd0);
        check("boot_word", bus.instr, 32'h100);
      end
      step();
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    bus.run = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    for (int i = 0; i < 6; i++) mem[8'($urandom)] = HALT;
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.instr_ready = $urandom_range(0, 3) != 0;
      bus.run = $urandom_range(0, 7) != 0;
      bus.redirect_valid = bus.halted ? $urandom_range(0, 3) == 0 : $urandom_range(0, 31) == 0;
      bus.redirect_addr = 8'($urandom);
      step();
    end
    bus.redirect_valid = 1'b0;
    check("rand_progress", 32'(pops > 300), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
